// File: rtl/inj_scheduler.sv
// rtl/inj_scheduler.sv - sequences one-shot injection buffers onto a shared router local port
// Optional watchdog: define SCHED_TIMEOUT_EN to build to_cnt and timeout_err.
module inj_scheduler #(
    parameter int NUM_SRC    = 4,
    parameter int FLIT_W     = 20,
    parameter int BURST_LEN  = 30,
    parameter int GAP_CYCLES = 4,
    parameter int TO_CYCLES  = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic [NUM_SRC-1:0]        src_enable,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*FLIT_W-1:0] src_data,
    output logic [FLIT_W-1:0]         inj_data,
    output logic                      inj_valid,
    output logic [3:0]                cur_src,
    output logic [15:0]               word_cnt,
    output logic                      busy,
    output logic                      all_done,
    output logic [NUM_SRC-1:0]        timeout_err,
    output logic                      stray_err
);

    // One width covers every run counter so the beat, gap and watchdog limits all fit.
    localparam int CNT_MAX = (BURST_LEN > GAP_CYCLES) ?
                             ((BURST_LEN > TO_CYCLES) ? BURST_LEN : TO_CYCLES) :
                             ((GAP_CYCLES > TO_CYCLES) ? GAP_CYCLES : TO_CYCLES);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_STREAM,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [3:0]         idx;
    logic [CNT_W-1:0]   beat_cnt;
    logic [CNT_W-1:0]   gap_cnt;
    logic               sel_valid;
    logic [FLIT_W-1:0]  sel_data;
    logic               other_valid;
    logic               start_ok;
    logic               last_beat;
    logic               gap_end;
    logic               last_src;
    logic               run_active;
    logic               stray_now;
    logic               timeout_hit;

    always_comb begin
        sel_valid   = 1'b0;
        sel_data    = '0;
        other_valid = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (idx == 4'(i)) begin
                sel_valid = src_valid[i];
                sel_data  = src_data[i*FLIT_W +: FLIT_W];
            end else begin
                other_valid = other_valid | src_valid[i];
            end
        end
    end

    assign start_ok   = start && (state == S_IDLE || state == S_DONE);
    assign last_beat  = (state == S_STREAM) && sel_valid && (beat_cnt == CNT_W'(BURST_LEN - 1));
    assign gap_end    = (state == S_GAP) && (gap_cnt == CNT_W'(GAP_CYCLES - 1));
    assign last_src   = (idx == 4'(NUM_SRC - 1));
    assign run_active = (state == S_ARM) || (state == S_STREAM) || (state == S_GAP);
    assign stray_now  = other_valid || (sel_valid && state != S_STREAM);
    assign cur_src    = idx;

`ifdef SCHED_TIMEOUT_EN
    logic [CNT_W-1:0] to_cnt;

    assign timeout_hit = (state == S_STREAM) && !sel_valid && (to_cnt == CNT_W'(TO_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt      <= '0;
            timeout_err <= '0;
        end else begin
            if (state == S_ARM) begin
                to_cnt <= '0;
            end else if (state == S_STREAM) begin
                to_cnt <= sel_valid ? '0 : to_cnt + 1'b1;
            end
            if (start_ok) begin
                timeout_err <= '0;
            end else begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (timeout_hit && idx == 4'(i)) begin
                        timeout_err[i] <= 1'b1;
                    end
                end
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        all_done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_ARM;
            end
            S_ARM: begin
                busy      = 1'b1;
                state_nxt = S_STREAM;
            end
            S_STREAM: begin
                busy = 1'b1;
                // A last beat is a valid cycle, so it can never coincide with a watchdog hit.
                if (last_beat || timeout_hit) state_nxt = S_GAP;
            end
            S_GAP: begin
                busy = 1'b1;
                if (gap_end) state_nxt = last_src ? S_DONE : S_ARM;
            end
            S_DONE: begin
                all_done = 1'b1;
                if (start) state_nxt = S_ARM;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_enable <= '0;
            inj_data   <= '0;
            inj_valid  <= 1'b0;
            idx        <= '0;
            word_cnt   <= '0;
            stray_err  <= 1'b0;
            beat_cnt   <= '0;
            gap_cnt    <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                src_enable[i] <= (state == S_ARM) && (idx == 4'(i));
            end

            inj_valid <= (state == S_STREAM) && sel_valid;
            if (state == S_STREAM && sel_valid) begin
                inj_data <= sel_data;
            end

            if (start_ok) begin
                idx       <= '0;
                word_cnt  <= '0;
                stray_err <= 1'b0;
            end else begin
                if (gap_end && !last_src) begin
                    idx <= idx + 4'd1;
                end
                // Late beats from the selected source still count even though they are dropped.
                if (run_active && sel_valid && word_cnt != 16'hFFFF) begin
                    word_cnt <= word_cnt + 16'd1;
                end
                if (stray_now) begin
                    stray_err <= 1'b1;
                end
            end

            if (state == S_ARM) begin
                beat_cnt <= '0;
            end else if (state == S_STREAM && sel_valid) begin
                beat_cnt <= beat_cnt + 1'b1;
            end

            gap_cnt <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
        end
    end

endmodule
